// File: rtl/muldiv_sequencer_pkg.sv
// Shared CPU definitions: ALU opcodes, flag bit positions and the
// sequencer's early-exit classification.
package muldiv_sequencer_pkg;

    // ALU opcodes shared by the ALU and every block that borrows it.
    localparam logic [4:0] ALU_OP_ADD = 5'd0;
    localparam logic [4:0] ALU_OP_SUB = 5'd1;
    localparam logic [4:0] ALU_OP_AND = 5'd2;
    localparam logic [4:0] ALU_OP_OR  = 5'd3;
    localparam logic [4:0] ALU_OP_XOR = 5'd4;

    // Flag bit indices inside the 4-bit flag word.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_S = 3;

    // Operation select on the op input.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // How an operation ended: full iteration, DIV overflow or DIV by zero.
    typedef enum logic [1:0] {
        EXIT_NORMAL = 2'd0,
        EXIT_OVF    = 2'd1,
        EXIT_DZ     = 2'd2
    } exit_e;

    // Assemble a flag word from individual flag values.
    function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                              input logic v, input logic s);
        logic [3:0] f;
        f         = 4'd0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_S] = s;
        return f;
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// 8x8 multiply / 16-by-8 divide sequencer that borrows the shared ALU for
// eight iterations. MUL accumulates shifted partial products with ADD;
// DIV runs restoring division with SUB, using the ALU carry as the borrow.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a_in,
    input  logic [7:0]  b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic        alu_req,
    output logic [4:0]  alu_op,
    output logic        alu_size,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_r,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ITER   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    state_e      state_r;
    state_e      state_nx_s;
    logic [2:0]  cnt_r;
    logic        op_r;
    logic [15:0] a_r;
    logic [7:0]  b_r;
    // MUL: running product. DIV: {remainder, quotient bits shifted in}.
    logic [15:0] acc_r;
    exit_e       exit_r;
    logic        busy_r;
    logic        done_r;
    logic        div_zero_r;
    logic [15:0] result_r;
    logic [3:0]  flags_r;

    logic [2:0]  bit_idx_s;
    logic [15:0] div_shift_s;
    logic [15:0] mul_term_s;
    logic        alu_req_s;
    logic [15:0] alu_a_s;
    logic [15:0] alu_b_s;
    logic        unused_flags_s;

    // Only the carry/borrow is consumed from the ALU flags.
    assign unused_flags_s = ^{alu_flags[FLAG_Z], alu_flags[FLAG_V], alu_flags[FLAG_S]};

    // Division walks dividend bits 7 down to 0 as the counter goes 0..7.
    assign bit_idx_s   = 3'd7 - cnt_r;
    assign div_shift_s = {7'd0, acc_r[15:8], a_r[bit_idx_s]};
    assign mul_term_s  = {8'd0, a_r[7:0]} << cnt_r;

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign result   = result_r;
    assign flags    = flags_r;
    assign alu_req  = alu_req_s;
    assign alu_a    = alu_a_s;
    assign alu_b    = alu_b_s;
    assign alu_op   = (op_r == OP_DIV) ? ALU_OP_SUB : ALU_OP_ADD;
    assign alu_size = 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode: early exits for DIV by zero and quotient overflow.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_CHECK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if ((op_r == OP_DIV) && ((b_r == 8'd0) || (a_r[15:8] >= b_r))) begin
                    state_nx_s = ST_FINISH;
                end else begin
                    state_nx_s = ST_ITER;
                end
            end
            ST_ITER: begin
                if (cnt_r == 3'd7) begin
                    state_nx_s = ST_FINISH;
                end else begin
                    state_nx_s = ST_ITER;
                end
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // ALU request and operands; the bus is quiet outside iteration.
    always_comb begin
        alu_req_s = 1'b0;
        alu_a_s   = 16'd0;
        alu_b_s   = 16'd0;
        if (state_r == ST_ITER) begin
            alu_req_s = 1'b1;
            if (op_r == OP_DIV) begin
                alu_a_s = div_shift_s;
                alu_b_s = {8'd0, b_r};
            end else begin
                alu_a_s = acc_r;
                alu_b_s = b_r[cnt_r] ? mul_term_s : 16'd0;
            end
        end else begin
            alu_req_s = 1'b0;
            alu_a_s   = 16'd0;
            alu_b_s   = 16'd0;
        end
    end

    // Operand capture, iteration datapath and registered completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= 3'd0;
            op_r       <= OP_MUL;
            a_r        <= 16'd0;
            b_r        <= 8'd0;
            acc_r      <= 16'd0;
            exit_r     <= EXIT_NORMAL;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            result_r   <= 16'd0;
            flags_r    <= 4'd0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= a_in;
                        b_r    <= b_in;
                        op_r   <= op;
                        busy_r <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    cnt_r <= 3'd0;
                    if (op_r == OP_DIV) begin
                        acc_r <= {a_r[15:8], 8'd0};
                        if (b_r == 8'd0) begin
                            exit_r <= EXIT_DZ;
                        end else if (a_r[15:8] >= b_r) begin
                            exit_r <= EXIT_OVF;
                        end else begin
                            exit_r <= EXIT_NORMAL;
                        end
                    end else begin
                        acc_r  <= 16'd0;
                        exit_r <= EXIT_NORMAL;
                    end
                end
                ST_ITER: begin
                    cnt_r <= cnt_r + 3'd1;
                    if (op_r == OP_MUL) begin
                        acc_r <= alu_r;
                    end else if (!alu_flags[FLAG_C]) begin
                        acc_r <= {alu_r[7:0], acc_r[6:0], 1'b1};
                    end else begin
                        acc_r <= {div_shift_s[7:0], acc_r[6:0], 1'b0};
                    end
                end
                ST_FINISH: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    cnt_r  <= 3'd0;
                    case (exit_r)
                        EXIT_DZ: begin
                            div_zero_r <= 1'b1;
                            result_r   <= a_r;
                            flags_r    <= 4'd0;
                        end
                        EXIT_OVF: begin
                            result_r <= a_r;
                            flags_r  <= pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
                        end
                        default: begin
                            result_r <= acc_r;
                            if (op_r == OP_DIV) begin
                                flags_r <= pack_flags(acc_r[7:0] == 8'd0, 1'b0, 1'b0, acc_r[7]);
                            end else begin
                                flags_r <= pack_flags(acc_r == 16'd0, 1'b0, 1'b0, acc_r[15]);
                            end
                        end
                    endcase
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: external ALU model, transaction
// level reference model, per-cycle comparison plus directed literal cases.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [15:0] a_in;
    logic [7:0]  b_in;
    logic        busy, done, div_zero;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        alu_req;
    logic [4:0]  alu_op;
    logic        alu_size;
    logic [15:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_flags;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .div_zero(div_zero), .result(result), .flags(flags),
        .alu_req(alu_req), .alu_op(alu_op), .alu_size(alu_size),
        .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    // Shared ALU: combinational ADD/SUB with carry = carry-out / borrow.
    logic [16:0] alu_wide;
    always_comb begin
        if (alu_op == ALU_OP_SUB) alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
        else                      alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r = alu_wide[15:0];
        alu_flags = pack_flags(alu_wide[15:0] == 16'd0, alu_wide[16], 1'b0, alu_wide[15]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flags;
        logic        dz;
        logic [3:0]  len;
    } pred_t;

    function automatic pred_t predict(input logic o, input logic [15:0] a, input logic [7:0] b);
        pred_t p;
        int q, r;
        p.dz = 1'b0;
        if (o == OP_MUL) begin
            p.res   = 16'(a[7:0] * b);
            p.flags = pack_flags(p.res == 16'd0, 1'b0, 1'b0, p.res[15]);
            p.len   = 4'd10;
        end else if (b == 8'd0) begin
            p.res = a; p.flags = 4'd0; p.dz = 1'b1; p.len = 4'd2;
        end else if (a[15:8] >= b) begin
            p.res = a; p.flags = pack_flags(1'b0, 1'b0, 1'b1, 1'b0); p.len = 4'd2;
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            p.res   = {8'(r), 8'(q)};
            p.flags = pack_flags(q == 0, 1'b0, 1'b0, q[7]);
            p.len   = 4'd10;
        end
        return p;
    endfunction

    // Expected ALU operand A during iteration step i.
    function automatic logic [31:0] exp_alu_a(input logic o, input logic [15:0] a,
                                              input logic [7:0] b, input int i);
        if (o == OP_MUL) return 32'(int'(a[7:0]) * (int'(b) & ((1 << i) - 1)));
        return 32'((((int'(a) >> (8 - i)) % int'(b)) * 2) + ((int'(a) >> (7 - i)) & 1));
    endfunction

    // Expected ALU operand B during iteration step i.
    function automatic logic [31:0] exp_alu_b(input logic o, input logic [15:0] a,
                                              input logic [7:0] b, input int i);
        if (o == OP_DIV) return 32'(b);
        return ((int'(b) >> i) & 1) != 0 ? 32'(int'(a[7:0]) << i) : 32'd0;
    endfunction

    logic        m_live = 1'b0;
    logic        m_busy, m_done, m_dz;
    logic [15:0] m_res;
    logic [3:0]  m_flags;
    int          m_k, m_len;
    logic        m_op;
    logic [15:0] m_a;
    logic [7:0]  m_b;
    pred_t       m_pred;

    // Transaction model: accept in idle, complete m_len edges after acceptance.
    always @(posedge clk) begin
        if (reset) begin
            m_live <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_res <= 16'd0; m_flags <= 4'd0; m_k <= 0; m_len <= 0;
        end else if (m_live) begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1; m_k <= 1; m_op <= op; m_a <= a_in; m_b <= b_in;
                    m_pred <= predict(op, a_in, b_in);
                    m_len  <= int'(predict(op, a_in, b_in).len);
                end
            end else if (m_k == m_len) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_dz <= m_pred.dz;
                m_res <= m_pred.res; m_flags <= m_pred.flags; m_k <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("div_zero", 32'(div_zero), 32'(m_dz));
            chk("result", 32'(result), 32'(m_res));
            chk("flags", 32'(flags), 32'(m_flags));
            chk("alu_size", 32'(alu_size), 32'd1);
            if (m_busy && m_len == 10 && m_k >= 2 && m_k <= 9) begin
                chk("alu_req", 32'(alu_req), 32'd1);
                chk("alu_op", 32'(alu_op), m_op ? 32'(ALU_OP_SUB) : 32'(ALU_OP_ADD));
                chk("alu_a", 32'(alu_a), exp_alu_a(m_op, m_a, m_b, m_k - 2));
                chk("alu_b", 32'(alu_b), exp_alu_b(m_op, m_a, m_b, m_k - 2));
            end else begin
                chk("alu_req_idle", 32'(alu_req), 32'd0);
                chk("alu_a_idle", 32'(alu_a), 32'd0);
                chk("alu_b_idle", 32'(alu_b), 32'd0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_op(input logic o, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] er, input logic [3:0] ef, input logic edz,
                         input int elat, input logic inject);
        int lat;
        lat = 0;
        @(posedge clk); #2;
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #2;
        start = 1'b0; a_in = 16'hDEAD; b_in = 8'hBE;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (inject && n == 3) begin
                start = 1'b1; op = ~o; a_in = 16'h0001; b_in = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(elat));
        chk("lit_result", 32'(result), 32'(er));
        chk("lit_flags", 32'(flags), 32'(ef));
        chk("lit_div_zero", 32'(div_zero), 32'(edz));
    endtask

    task automatic no_done_window(input string nm);
        int seen;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = 16'd0; b_in = 8'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_alu_req", 32'(alu_req), 32'd0);

        do_op(OP_MUL, 16'h0012, 8'h34, 16'h03A8, 4'b0000, 1'b0, 10, 1'b0);
        do_op(OP_MUL, 16'h00FF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 10, 1'b0);
        do_op(OP_DIV, 16'h1234, 8'h56, 16'h1036, 4'b0000, 1'b0, 10, 1'b0);
        do_op(OP_DIV, 16'h1234, 8'h12, 16'h1234, 4'b0100, 1'b0, 2, 1'b0);
        do_op(OP_DIV, 16'h0100, 8'h00, 16'h0100, 4'b0000, 1'b1, 2, 1'b0);
        do_op(OP_MUL, 16'h0000, 8'h05, 16'h0000, 4'b0001, 1'b0, 10, 1'b0);
        do_op(OP_DIV, 16'h0005, 8'h07, 16'h0500, 4'b0001, 1'b0, 10, 1'b0);
        // start pulse while busy must be ignored and not queued
        do_op(OP_MUL, 16'h0003, 8'h05, 16'h000F, 4'b0000, 1'b0, 10, 1'b1);
        no_done_window("no_queued_op");

        // reset during ITER cycle 4 abandons the operation
        @(posedge clk); #2;
        start = 1'b1; op = OP_MUL; a_in = 16'h0077; b_in = 8'h66;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_done", 32'(done), 32'd0);
        no_done_window("abandoned_done");
        do_op(OP_MUL, 16'h0012, 8'h34, 16'h03A8, 4'b0000, 1'b0, 10, 1'b0);

        // randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] bb, hi;
            @(posedge clk); #2;
            bb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bb = 8'd0;
            hi = 8'($urandom);
            if (bb != 8'd0 && $urandom_range(0, 3) != 0) hi = hi % bb;
            start = ($urandom_range(0, 2) == 0);
            op    = 1'($urandom);
            b_in  = bb;
            a_in  = {hi, 8'($urandom)};
            reset = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk); #2;
        start = 1'b0; reset = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  request pulse; sampled only in IDLE.
REQ-004 op  in  1  0 = MUL (a_in[7:0] * b_in), 1 = DIV (a_in / b_in).
REQ-005 a_in  in  16  multiplicand (low byte, MUL) or dividend (DIV); captured on accepted start.
REQ-006 b_in  in  8  multiplier or divisor; captured on accepted start.
REQ-007 busy  out  1  high from the edge after start is accepted until return to IDLE.
REQ-008 done  out  1  single-cycle completion pulse.
REQ-009 div_zero  out  1  single-cycle pulse, coincident with done, on DIV by zero.
REQ-010 result  out  16  MUL: product. DIV: {remainder, quotient}. Held until next accepted start.
REQ-011 flags  out  4  Z,C,V,S at the shared flag bit indices (Z=0, C=1, V=2, S=3). Held with result.
REQ-012 alu_req  out  1  high while the sequencer owns the shared ALU (ITER only).
REQ-013 alu_op  out  5  ALU opcode: ADD for MUL, SUB for DIV.
REQ-014 alu_size  out  1  constant 1 (word).
REQ-015 alu_a, alu_b  out  16 each  ALU operands.
REQ-016 alu_r  in  16  ALU result, combinational, same cycle.
REQ-017 alu_flags  in  4  ALU flags, same cycle.

Function
REQ-018 States: IDLE, CHECK, ITER, FINISH. The 3-bit iteration counter counts 0..7.
REQ-019 IDLE: if start is high at edge E0, capture operands and op, then go to CHECK. If start is low, stay in IDLE.
REQ-020 CHECK lasts 1 cycle. On DIV with b=0, go to FINISH with div_zero. On DIV with a[15:8] >= b, go to FINISH with overflow. Otherwise go to ITER with counter = 0.
REQ-021 MUL init: acc = 0. Each ITER cycle i: alu_a = acc, alu_b = b[i] ? (mcand << i) : 0. acc <= alu_r.
REQ-022 DIV init: rem = a[15:8]. Each ITER cycle (bits 7 down to 0): shifted = {rem, a[bit]}; alu_a = shifted, alu_b = {8'd0, b}.
  - If alu_flags.C = 0: rem <= alu_r[7:0] and the quotient bit = 1.
  - Otherwise: rem <= shifted[7:0] and the quotient bit = 0.
REQ-023 ITER lasts exactly 8 cycles, then FINISH.
REQ-024 FINISH lasts 1 cycle: done = 1, result and flags update, then IDLE.
  - Normal op: done is high in the cycle after E10.
  - Early exit: done is high in the cycle after E2.
REQ-025 MUL flags: Z = (result == 0), S = result[15], C = 0, V = 0.
REQ-026 DIV normal flags: Z = (quotient == 0), S = quotient[7], C = 0, V = 0.
REQ-027 DIV overflow: result = a unchanged, V = 1, Z = S = C = 0.
REQ-028 DIV by zero: result = a unchanged, flags = 0, div_zero = 1.
REQ-029 start while busy is ignored; no queuing.
REQ-030 Outside ITER: alu_req = 0 and alu_a = alu_b = 0.
REQ-031 A start held high across FINISH is accepted again only once IDLE is reached.

Reset
REQ-032 reset forces IDLE, busy = 0, done = 0, div_zero = 0, alu_req = 0, result = 0, flags = 0, counter = 0.
REQ-033 Reset mid-operation abandons the operation; no done pulse is produced for it.

Structure
REQ-034 ALU opcode constants and flag indices live in the shared CPU package, used by both the ALU and this block.
REQ-035 The state enum is local to the module.
REQ-036 No sub-module: the ALU is external and shared, and its use is signalled by alu_req.

Verification
REQ-037 MUL a=0x0012, b=0x34 -> done after E10, result=0x03A8, flags Z=0 S=0 C=0 V=0.
REQ-038 MUL a=0x00FF, b=0xFF -> result=0xFE01, S=1, Z=0.
REQ-039 DIV a=0x1234, b=0x56 -> done after E10, result=0x1036 (rem 0x10, quot 0x36), Z=0 S=0.
REQ-040 DIV a=0x1234, b=0x12 -> done after E2, V=1, result=0x1234, alu_req never high.
REQ-041 DIV a=0x0100, b=0x00 -> done and div_zero after E2, result=0x0100, flags=0.
REQ-042 Reset and busy handling:
  - Start MUL, assert reset in ITER cycle 4 -> next cycle busy=0 and no done pulse.
  - A start pulse during busy -> ignored.
  - A fresh MUL after reset -> completes correctly.
